velocity_control_reset_delay_line: RTL and testbench
====================================================

# velocity_control_reset_delay_line

Parametrised multi-channel, multi-stage resettable delay line for the velocity-control datapath. It replaces the single-sample resettable delay used between controller stages. It delays CHANNELS signed samples by DEPTH enabled clock ticks and supports a synchronous controller clear that zeroes the whole line. It also reports when the line holds DEPTH valid samples since the last clear or reset, so downstream integrators/differentiators can ignore start-up transients.

## Interface
- WIDTH, 32, signed sample width per channel (>= 2)
- DEPTH, 4, delay in enabled ticks (>= 1; 0 is a configuration error, elaboration must fail)
- CHANNELS, 2, independent channels sharing enable/clear (>= 1)
- CLK_IN  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately
- enb  in  1  clock enable (rate strobe); line advances only when 1
- clear  in  1  synchronous controller clear, active-high
- In  in  CHANNELS*WIDTH  signed samples; channel k at bits [k*WIDTH +: WIDTH]
- Out  out  CHANNELS*WIDTH  signed delayed samples, same packing
- out_valid  out  1  line primed (DEPTH enabled samples since last clear/reset) and clear low
- fill_count  out  clog2(DEPTH+1)  number of valid stages, saturating at DEPTH

## Operation
- State: per channel, stages s[0..DEPTH-1] of WIDTH bits; shared fill counter `fill`.
- Reset (reset=0, asynchronous): all stages = 0, fill = 0. Outputs while and after reset: Out = 0, out_valid = 0, fill_count = 0.
- Clear has priority over enb. On a rising edge with clear=1, regardless of enb: all stages = 0, fill = 0.
- Shift: on a rising edge with clear=0 and enb=1:
  - s[0] <= In
  - s[i] <= s[i-1]
  - fill <= min(fill+1, DEPTH)
- Hold: on a rising edge with clear=0 and enb=0, all state holds.
- Out = clear ? 0 : s[DEPTH-1], per channel. This combinational gating matches the single-stage block's output switch.
- out_valid = (fill == DEPTH) & ~clear.
- fill_count = fill, registered and not gated by clear.
- Data is passed bit-exact: no arithmetic, no saturation, no sign change. Channels are fully independent in data and identical in control.

## Timing
- Latency: a sample presented with enb=1 at edge t appears on Out after DEPTH enabled edges. With enb tied high, it is valid on Out after edge t+DEPTH-1, i.e. during cycle t+DEPTH-1 to t+DEPTH.
- Clear asserted combinationally forces Out=0 and out_valid=0 in the same cycle. The state is zero from the following edge.
- If clear and enb are both 1 on an edge, In is discarded (not loaded into s[0]).
- The first enabled edge after clear deasserts loads s[0]. out_valid rises after exactly DEPTH enabled edges with clear=0.
- fill saturates: further enabled edges keep fill = DEPTH, with no wrap.
- Reset asserted mid-fill or mid-operation: all state is lost immediately, asynchronously. Deassertion is expected to be synchronised externally. The first edge after release behaves as post-clear.
- DEPTH=1: Out = s[0]; out_valid rises after the first enabled edge.

## Test plan
- Reset: reset=0 with In = 0x7FFFFFFF, enb=1 -> Out=0, out_valid=0, fill_count=0. Then release, defaults.
- Fill/latency: enb=1, In ch0 = 1,2,3,4,5… -> Out ch0 = 0,0,0 then 1 after the 4th edge. out_valid rises with fill_count=4 and stays there.
- Enable gating: enb toggles 1,0,1,0 with a ramp input -> the line advances only on enb=1 edges. Out reaches the first sample after 4 enabled edges (8 clocks).
- Clear mid-stream: primed line with Out=0x00000010, then clear=1 for one cycle with enb=1 -> Out=0 and out_valid=0 in that cycle. After the edge, all stages = 0 and fill_count=0. The sample presented during clear never appears.
- Channel independence/sign: ch0 = -5 (0xFFFFFFFB), ch1 = 0x7FFFFFFF -> both appear unmodified after DEPTH, with no cross-talk.
- Async reset mid-fill: reset pulsed low between edges at fill_count=2 -> outputs go to 0 immediately, without waiting for an edge. Refill then takes a full 4 enabled edges.

Source files
------------

// File: rtl/velocity_control_reset_delay_line.sv
// Multi-channel resettable delay line: delays CHANNELS signed samples by DEPTH enabled ticks,
// with a synchronous clear and a primed indicator for start-up transient masking.
module velocity_control_reset_delay_line #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                          CLK_IN,
  input  logic                          reset,
  input  logic                          enb,
  input  logic                          clear,
  input  logic [CHANNELS*WIDTH-1:0]     In,
  output logic [CHANNELS*WIDTH-1:0]     Out,
  output logic                          out_valid,
  output logic [$clog2(DEPTH+1)-1:0]    fill_count
);

  localparam int unsigned LINE_W = CHANNELS * WIDTH;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  // Reject configurations the line cannot represent.
  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("velocity_control_reset_delay_line: DEPTH must be >= 1");
    end
    if (WIDTH < 2) begin : g_bad_width
      $error("velocity_control_reset_delay_line: WIDTH must be >= 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
      $error("velocity_control_reset_delay_line: CHANNELS must be >= 1");
    end
  endgenerate

  // All channels share control, so each stage carries the full packed channel vector.
  logic [LINE_W-1:0] stage [DEPTH];
  logic [FILL_W-1:0] fill;

  // Clear wins over enable; the sample presented during a clear is dropped.
  always_ff @(posedge CLK_IN or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      fill <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      fill <= '0;
    end else if (enb) begin
      stage[0] <= In;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
    end
  end

  // Clear gates the data path in the same cycle, matching the single-stage output switch.
  always_comb begin
    Out       = '0;
    out_valid = 1'b0;
    if (!clear) begin
      Out       = stage[DEPTH-1];
      out_valid = (fill == FILL_MAX);
    end
  end

  assign fill_count = fill;

endmodule

// File: tb/tb_velocity_control_reset_delay_line.sv
// Randomized self-checking bench for velocity_control_reset_delay_line against a
// queue-based model of the last DEPTH accepted samples.
module tb_velocity_control_reset_delay_line;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned CH = 2;
  localparam int unsigned CW = CH * W;
  localparam int unsigned FW = $clog2(D + 1);

  logic          clk_in = 1'b0;
  logic          reset;
  logic          enb;
  logic          clear;
  logic [CW-1:0] in_data;
  logic [CW-1:0] out_data;
  logic          out_valid;
  logic [FW-1:0] fill_count;

  int vecs = 0;
  int errs = 0;

  // Samples accepted since the last clear/reset, oldest first, capped at D.
  logic [CW-1:0] hist [$];

  velocity_control_reset_delay_line #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH)) dut (
    .CLK_IN    (clk_in),
    .reset     (reset),
    .enb       (enb),
    .clear     (clear),
    .In        (in_data),
    .Out       (out_data),
    .out_valid (out_valid),
    .fill_count(fill_count)
  );

  always #5 clk_in = ~clk_in;

  function automatic void model_edge();
    if (!reset || clear) begin
      hist.delete();
    end else if (enb) begin
      hist.push_back(in_data);
      if (hist.size() > D) void'(hist.pop_front());
    end
  endfunction

  function automatic logic [CW-1:0] exp_out();
    if (clear || hist.size() != D) return '0;
    return hist[0];
  endfunction

  function automatic logic exp_valid();
    return (hist.size() == D) && !clear;
  endfunction

  function automatic logic [FW-1:0] exp_fill();
    return FW'(hist.size());
  endfunction

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [CW-1:0] d);
    enb = e; clear = c; in_data = d;
    #2;
  endtask

  task automatic test_reset();
    logic [CW-1:0] big;
    big = {CH{32'h7FFF_FFFF}};
    reset = 1'b0; enb = 1'b1; clear = 1'b0; in_data = big;
    hist.delete();
    repeat (3) tick();
    #2;
    vecs++; if (out_data !== '0) begin $display("FAIL reset_out got=%h exp=0", out_data); errs++; end
    vecs++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", out_valid); errs++; end
    vecs++; if (fill_count !== '0) begin $display("FAIL reset_fill got=%0d exp=0", fill_count); errs++; end
    @(posedge clk_in); #1;
    reset = 1'b1; enb = 1'b0; clear = 1'b0; in_data = '0;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b0, {32'(100 + k), 32'(k)});
      tick();
      #2;
      vecs++;
      if (out_data[W-1:0] !== ((k >= 4) ? 32'(k - 3) : 32'd0)) begin
        $display("FAIL fill_ch0 edge=%0d got=%h exp=%h", k, out_data[W-1:0], (k >= 4) ? 32'(k - 3) : 32'd0); errs++;
      end
      vecs++;
      if (out_valid !== (k >= 4)) begin $display("FAIL fill_valid edge=%0d got=%b exp=%b", k, out_valid, k >= 4); errs++; end
      vecs++;
      if (fill_count !== FW'((k >= 4) ? 4 : k)) begin
        $display("FAIL fill_count edge=%0d got=%0d exp=%0d", k, fill_count, (k >= 4) ? 4 : k); errs++;
      end
    end
  endtask

  task automatic test_enable_gating();
    drive(1'b0, 1'b1, '0);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(k % 2 == 0, 1'b0, {32'(500 + k), 32'(50 + k)});
      tick();
      #2;
      vecs++; if (out_data !== exp_out()) begin $display("FAIL gate_out clk=%0d got=%h exp=%h", k, out_data, exp_out()); errs++; end
      vecs++; if (fill_count !== exp_fill()) begin $display("FAIL gate_fill clk=%0d got=%0d exp=%0d", k, fill_count, exp_fill()); errs++; end
    end
    vecs++; if (out_data[W-1:0] !== 32'd50) begin $display("FAIL gate_first got=%h exp=%h", out_data[W-1:0], 32'd50); errs++; end
    vecs++; if (fill_count !== FW'(4)) begin $display("FAIL gate_fill_end got=%0d exp=4", fill_count); errs++; end
  endtask

  task automatic test_clear();
    drive(1'b1, 1'b0, {CH{32'h0000_0010}});
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, {CH{32'(k + 1)}});
      tick();
    end
    drive(1'b0, 1'b0, '0);
    vecs++; if (out_data[W-1:0] !== 32'h10) begin $display("FAIL clr_primed got=%h exp=10", out_data[W-1:0]); errs++; end
    drive(1'b1, 1'b1, {CH{32'hDEAD_BEEF}});
    vecs++; if (out_data !== '0) begin $display("FAIL clr_out got=%h exp=0", out_data); errs++; end
    vecs++; if (out_valid !== 1'b0) begin $display("FAIL clr_valid got=%b exp=0", out_valid); errs++; end
    vecs++; if (fill_count !== FW'(4)) begin $display("FAIL clr_fill_ungated got=%0d exp=4", fill_count); errs++; end
    tick();
    drive(1'b0, 1'b0, '0);
    vecs++; if (fill_count !== '0) begin $display("FAIL clr_fill_after got=%0d exp=0", fill_count); errs++; end
    for (int k = 0; k < D + 2; k++) begin
      drive(1'b1, 1'b0, {CH{32'(200 + k)}});
      vecs++;
      if (out_data !== exp_out() || out_data[W-1:0] === 32'hDEAD_BEEF) begin
        $display("FAIL clr_refill clk=%0d got=%h exp=%h", k, out_data, exp_out()); errs++;
      end
      tick();
    end
  endtask

  task automatic test_channels();
    logic [CW-1:0] samp;
    samp = {32'h7FFF_FFFF, 32'hFFFF_FFFB};
    drive(1'b1, 1'b0, samp);
    tick();
    for (int k = 1; k < D; k++) begin
      drive(1'b1, 1'b0, '0);
      tick();
    end
    drive(1'b0, 1'b0, '0);
    vecs++; if (out_data[W-1:0] !== 32'hFFFF_FFFB) begin $display("FAIL chan0 got=%h exp=fffffffb", out_data[W-1:0]); errs++; end
    vecs++; if (out_data[2*W-1:W] !== 32'h7FFF_FFFF) begin $display("FAIL chan1 got=%h exp=7fffffff", out_data[2*W-1:W]); errs++; end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, '0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, {CH{32'(300 + k)}});
      tick();
    end
    drive(1'b0, 1'b0, '0);
    vecs++; if (fill_count !== FW'(2)) begin $display("FAIL ar_pre_fill got=%0d exp=2", fill_count); errs++; end
    reset = 1'b0;
    hist.delete();
    #1;
    vecs++; if (fill_count !== '0) begin $display("FAIL ar_fill got=%0d exp=0", fill_count); errs++; end
    vecs++; if (out_data !== '0 || out_valid !== 1'b0) begin $display("FAIL ar_out got=%h/%b exp=0/0", out_data, out_valid); errs++; end
    enb = 1'b1;
    tick();
    reset = 1'b1;
    for (int k = 1; k <= D; k++) begin
      drive(1'b1, 1'b0, {CH{32'(400 + k)}});
      tick();
      #2;
      vecs++;
      if (out_valid !== (k == D)) begin $display("FAIL ar_refill_valid edge=%0d got=%b exp=%b", k, out_valid, k == D); errs++; end
    end
    vecs++; if (out_data[W-1:0] !== 32'd401) begin $display("FAIL ar_refill_out got=%h exp=%h", out_data[W-1:0], 32'd401); errs++; end
  endtask

  task automatic test_random();
    logic [CW-1:0] d;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < CH; k++) d[k*W +: W] = $urandom;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, d);
      vecs++; if (out_data !== exp_out()) begin $display("FAIL rnd_out n=%0d got=%h exp=%h", n, out_data, exp_out()); errs++; end
      vecs++; if (out_valid !== exp_valid()) begin $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, out_valid, exp_valid()); errs++; end
      vecs++; if (fill_count !== exp_fill()) begin $display("FAIL rnd_fill n=%0d got=%0d exp=%0d", n, fill_count, exp_fill()); errs++; end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; enb = 1'b0; clear = 1'b0; in_data = '0;
    #1;
    test_reset();
    test_fill();
    test_enable_gating();
    test_clear();
    test_channels();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
